// File: rtl/keypad_driver.sv
// keypad_driver: scans a 3x4 phone keypad and reports debounced key presses.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   C, A, E   in   column inputs (left, middle, right), high = key in driven row pressed
//   B,G,F,D   out  one-hot row drives (rows 1..4), registered
//   DATA_S    out  4-bit code of the last accepted key
//   INTERUPT  out  high for INTR_CYCLES clocks when a new press is accepted
module keypad_driver #(
    parameter int SCAN_DIV    = 1,
    parameter int DEBOUNCE    = 2,
    parameter int INTR_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       C,
    input  logic       A,
    input  logic       E,
    output logic       B,
    output logic       G,
    output logic       F,
    output logic       D,
    output logic [3:0] DATA_S,
    output logic       INTERUPT
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int IW = INTR_CYCLES > 1 ? $clog2(INTR_CYCLES) : 1;
    localparam logic [3:0] NO_KEY = 4'hF;

    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [3:0]    rows;
    logic          found;
    logic [3:0]    held_code;
    logic [3:0]    prev_code;
    logic [CW-1:0] cnt;
    logic          key_down;
    logic [IW-1:0] intr_cnt;

    logic          slot_end;
    logic          frame_end;
    logic          any_col;
    logic [1:0]    col_sel;
    logic [3:0]    code_now;
    logic [3:0]    frame_code;
    logic [CW-1:0] cnt_next;
    logic          stable;
    logic          accept;
    logic          drop;

    assign B = rows[0];
    assign G = rows[1];
    assign F = rows[2];
    assign D = rows[3];

    always_comb begin
        slot_end   = div == DW'(SCAN_DIV - 1);
        frame_end  = slot_end && idx == 2'd3;
        any_col    = C | A | E;
        // leftmost active column wins inside a row
        col_sel    = C ? 2'd0 : A ? 2'd1 : 2'd2;
        code_now   = idx == 2'd3 ? (col_sel == 2'd0 ? 4'hA : col_sel == 2'd1 ? 4'h0 : 4'hB)
                                 : 4'(idx) * 4'd3 + 4'(col_sel) + 4'd1;
        // a hit latched in an earlier row of this frame takes priority
        frame_code = found ? held_code : any_col ? code_now : NO_KEY;
        cnt_next   = frame_code != prev_code ? CW'(1)
                   : cnt == CW'(DEBOUNCE) ? cnt : cnt + CW'(1);
        stable     = cnt_next == CW'(DEBOUNCE);
        accept     = frame_end && !key_down && frame_code != NO_KEY && stable;
        drop       = frame_end && key_down && frame_code == NO_KEY && stable;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div       <= '0;
            idx       <= 2'd0;
            rows      <= 4'b0001;
            found     <= 1'b0;
            held_code <= NO_KEY;
            prev_code <= NO_KEY;
            cnt       <= '0;
            key_down  <= 1'b0;
            DATA_S    <= 4'h0;
            INTERUPT  <= 1'b0;
            intr_cnt  <= '0;
        end else begin
            div <= slot_end ? '0 : div + DW'(1);
            if (slot_end) begin
                idx  <= idx + 2'd1;
                rows <= {rows[2:0], rows[3]};
                if (frame_end) begin
                    found     <= 1'b0;
                    prev_code <= frame_code;
                    cnt       <= cnt_next;
                end else if (!found && any_col) begin
                    found     <= 1'b1;
                    held_code <= code_now;
                end
            end
            if (accept) begin
                key_down <= 1'b1;
                DATA_S   <= frame_code;
            end else if (drop) begin
                key_down <= 1'b0;
            end
            // a press landing while the pulse is still high does not stretch it
            if (accept && !INTERUPT) begin
                INTERUPT <= 1'b1;
                intr_cnt <= IW'(INTR_CYCLES - 1);
            end else if (INTERUPT) begin
                if (intr_cnt == '0)
                    INTERUPT <= 1'b0;
                else
                    intr_cnt <= intr_cnt - IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_keypad_driver.sv
// tb_keypad_driver: directed and random keypad stimulus checked against a frame-level model.
module tb_keypad_driver;
    localparam int S  = 2;
    localparam int DB = 2;
    localparam int IC = 4;
    localparam int FR = 4 * S;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       C = 1'b0;
    logic       A = 1'b0;
    logic       E = 1'b0;
    logic       B, G, F, D;
    logic [3:0] DATA_S;
    logic       INTERUPT;

    keypad_driver #(.SCAN_DIV(S), .DEBOUNCE(DB), .INTR_CYCLES(IC)) dut (
        .CLK(CLK), .RST(RST), .C(C), .A(A), .E(E),
        .B(B), .G(G), .F(F), .D(D), .DATA_S(DATA_S), .INTERUPT(INTERUPT)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] pressed = '0;
    int          n;
    int          hist[$];
    bit          kd;
    logic [3:0]  m_data;
    int          rem;
    int          pulses;
    logic        prev_int;
    int          code_tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // key order 1,2,3,4,...,*,0,# is exactly the row-then-column priority
    function automatic int frame_code();
        for (int k = 0; k < 12; k++)
            if (pressed[k]) return code_tab[k];
        return 15;
    endfunction

    function automatic bit last_all(input int code);
        if (hist.size() < DB) return 1'b0;
        for (int k = 0; k < DB; k++)
            if (hist[hist.size() - 1 - k] != code) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        n = 0;
        hist.delete();
        kd = 1'b0;
        m_data = 4'h0;
        rem = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int code;
        acc = 1'b0;
        if (n % FR == FR - 1) begin
            code = frame_code();
            hist.push_back(code);
            if (hist.size() > DB) void'(hist.pop_front());
            if (!kd && code != 15 && last_all(code)) begin
                acc = 1'b1;
                kd = 1'b1;
                m_data = code[3:0];
            end else if (kd && code == 15 && last_all(15)) begin
                kd = 1'b0;
            end
        end
        rem = (acc && rem == 0) ? IC : (rem > 0 ? rem - 1 : 0);
        n++;
    endtask

    task automatic cycle();
        int r;
        r = (n / S) % 4;
        C = pressed[r * 3];
        A = pressed[r * 3 + 1];
        E = pressed[r * 3 + 2];
        chk("rows", 32'({D, F, G, B}), 32'(1) << r);
        chk("data", 32'(DATA_S), 32'(m_data));
        chk("intr", 32'(INTERUPT), 32'(rem > 0));
        if (INTERUPT === 1'b1 && prev_int !== 1'b1) pulses++;
        prev_int = INTERUPT;
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic frames(input logic [11:0] m, input int k);
        pressed = m;
        repeat (k * FR) cycle();
    endtask

    initial begin
        int          sel;
        logic [11:0] m;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        RST = 1'b0;
        prev_int = 1'b0;
        pulses = 0;
        chk("rst_rows", 32'({D, F, G, B}), 32'h1);
        chk("rst_data", 32'(DATA_S), 32'h0);
        chk("rst_intr", 32'(INTERUPT), 32'h0);
        frames(12'h000, 2);

        frames(12'h010, 4);
        chk("k5_data", 32'(DATA_S), 32'h5);
        chk("k5_pulses", pulses, 1);
        frames(12'h000, 3);

        frames(12'h800, 3);
        frames(12'h000, 3);
        chk("hash_data", 32'(DATA_S), 32'hB);
        frames(12'h200, 3);
        frames(12'h000, 3);
        chk("star_data", 32'(DATA_S), 32'hA);
        chk("hash_star_pulses", pulses, 3);

        frames(12'h040, 1);
        frames(12'h000, 3);
        chk("glitch_data", 32'(DATA_S), 32'hA);
        chk("glitch_pulses", pulses, 3);

        frames(12'h101, 5);
        chk("multi_data", 32'(DATA_S), 32'h1);
        chk("multi_pulses", pulses, 4);
        frames(12'h000, 3);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            m = '0;
            if (sel == 1 || sel == 2) begin
                m[$urandom_range(0, 11)] = 1'b1;
            end else if (sel == 3) begin
                m[$urandom_range(0, 11)] = 1'b1;
                m[$urandom_range(0, 11)] = 1'b1;
            end
            frames(m, int'($urandom_range(1, 4)));
        end
        frames(12'h000, 3);

        pressed = 12'h004;
        for (int i = 0; i < 6 * FR && rem == 0; i++) cycle();
        chk("intr_before_rst", 32'(INTERUPT), 32'h1);
        cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        chk("mid_pulse_rst_intr", 32'(INTERUPT), 32'h0);
        chk("mid_pulse_rst_data", 32'(DATA_S), 32'h0);
        chk("mid_pulse_rst_rows", 32'({D, F, G, B}), 32'h1);
        frames(12'h000, 3);

        frames(12'h080, 1);
        repeat (3) cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        frames(12'h080, 1);
        chk("mid_debounce_rst_data", 32'(DATA_S), 32'h0);
        frames(12'h080, 2);
        chk("k8_data", 32'(DATA_S), 32'h8);
        frames(12'h000, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
